uart_word_rx: RTL and testbench

- UART receiver and word assembler on the serial download path. It deserialises 8N1 frames from the synchronised `rx` pin and packs 4 consecutive bytes little-endian into a 32-bit instruction word.
- It presents each complete word to the communication controller with a one-cycle valid pulse.
- It sits directly upstream of the CPU communication controller, which consumes `instr`/`word_valid` to feed the CPU.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_word_rx_if.sv | 36 +++
 rtl/uart_rx_byte.sv | 170 +++++++++++++++++
 rtl/uart_word_rx.sv | 94 +++++++++
 tb/tb_uart_word_rx.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
// Shared types and sizes for the serial download receiver.
// Optional even parity is selected with UART_PARITY_EN.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int DATA_BITS      = 8;

endpackage

// File: rtl/uart_word_rx_if.sv
// Receiver-side bundle: serial pin and flush in, byte/word strobes out.
// slave is the receiver, master is the consumer/driver side.
interface uart_word_rx_if;
    import uart_pkg::*;

    logic                   rx;
    logic                   clr;
    logic [DATA_BITS-1:0]   byte_data;
    logic                   byte_valid;
    logic [31:0]            instr;
    logic                   word_valid;
    logic                   frame_err;
    logic                   busy;

    modport slave (
        input  rx,
        input  clr,
        output byte_data,
        output byte_valid,
        output instr,
        output word_valid,
        output frame_err,
        output busy
    );

    modport master (
        output rx,
        output clr,
        input  byte_data,
        input  byte_valid,
        input  instr,
        input  word_valid,
        input  frame_err,
        input  busy
    );
endinterface

// File: rtl/uart_rx_byte.sv
// 8N1 byte receiver: 2-flop synchroniser, bit FSM, byte/error strobes.
// With UART_PARITY_EN an even-parity bit is checked before the stop bit.
module uart_rx_byte
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 rx_i,
    output logic [DATA_BITS-1:0] byte_o,
    output logic                 byte_valid_o,
    output logic                 frame_err_o,
    output logic                 busy_o,
    output logic                 start_o,
    output logic                 idle_o
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic [1:0]           sync_q;
    rx_state_t            state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 byte_valid_q, byte_valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 busy_q, busy_d;
    logic                 wait_hi_q, wait_hi_d;
    logic                 par_bad;
    logic                 rxs;

`ifdef UART_PARITY_EN
    logic par_err_q, par_err_d;
    assign par_bad = par_err_q;
`else
    assign par_bad = 1'b0;
`endif

    assign rxs          = sync_q[1];
    assign byte_o       = byte_q;
    assign byte_valid_o = byte_valid_q;
    assign frame_err_o  = frame_err_q;
    assign busy_o       = busy_q;
    assign idle_o       = (state_q == IDLE);

    // State and datapath registers; synchroniser presets to line-idle.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_q       <= 2'b11;
            state_q      <= IDLE;
            cnt_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            byte_q       <= '0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            busy_q       <= 1'b0;
            wait_hi_q    <= 1'b0;
`ifdef UART_PARITY_EN
            par_err_q    <= 1'b0;
`endif
        end else begin
            sync_q       <= {sync_q[0], rx_i};
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            byte_q       <= byte_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            busy_q       <= busy_d;
            wait_hi_q    <= wait_hi_d;
`ifdef UART_PARITY_EN
            par_err_q    <= par_err_d;
`endif
        end
    end

    // Bit FSM: mid-bit sampling, glitch rejection, stop/parity check.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        byte_d       = byte_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        busy_d       = busy_q;
        wait_hi_d    = wait_hi_q;
        start_o      = 1'b0;
`ifdef UART_PARITY_EN
        par_err_d    = par_err_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (wait_hi_q) begin
                    if (rxs) wait_hi_d = 1'b0;
                end else if (!rxs) begin
                    state_d = START;
                    cnt_d   = HALF;
                    start_o = 1'b1;
                end
            end
            START: begin
                if (cnt_q == '0) begin
                    if (!rxs) begin
                        state_d = DATA;
                        cnt_d   = FULL;
                        bit_d   = '0;
                        busy_d  = 1'b1;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DATA: begin
                if (cnt_q == '0) begin
                    shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                    cnt_d   = FULL;
                    bit_d   = bit_q + 1'b1;
                    if (bit_q == LAST_BIT) begin
`ifdef UART_PARITY_EN
                        state_d = PARITY;
`else
                        state_d = STOP;
`endif
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`ifdef UART_PARITY_EN
            PARITY: begin
                if (cnt_q == '0) begin
                    par_err_d = (^shift_q) ^ rxs;
                    cnt_d     = FULL;
                    state_d   = STOP;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
`endif
            STOP: begin
                if (cnt_q == '0) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    if (rxs && !par_bad) begin
                        byte_d       = shift_q;
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        wait_hi_d   = !rxs;
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_word_rx.sv
// Packs received bytes little-endian into 32-bit words, with idle timeout
// and flush. Parity checking is enabled with UART_PARITY_EN.
module uart_word_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT      = 868,
    parameter int IDLE_TIMEOUT_BITS = 40
) (
    input  logic           clk,
    input  logic           reset,
    uart_word_rx_if.slave  bus
);

    localparam int NW  = $clog2(BYTES_PER_WORD);
    localparam int TMO = IDLE_TIMEOUT_BITS * CLKS_PER_BIT;
    localparam int TW  = $clog2(TMO + 1);
    localparam logic [NW-1:0] LAST_IDX = NW'(BYTES_PER_WORD - 1);
    localparam logic [TW-1:0] TMO_LAST = TW'(TMO - 1);

    logic [DATA_BITS-1:0] byte_data;
    logic                 byte_valid;
    logic                 frame_err;
    logic                 start;
    logic                 idle;
    logic                 word_fire;

    logic [NW-1:0]                             cnt_q, cnt_d;
    logic [BYTES_PER_WORD-2:0][DATA_BITS-1:0]  buf_q, buf_d;
    logic [31:0]                               instr_q, instr_d;
    logic [TW-1:0]                             tmo_q, tmo_d;

    uart_rx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_byte (
        .clk          (clk),
        .reset        (reset),
        .rx_i         (bus.rx),
        .byte_o       (byte_data),
        .byte_valid_o (byte_valid),
        .frame_err_o  (frame_err),
        .busy_o       (bus.busy),
        .start_o      (start),
        .idle_o       (idle)
    );

    assign bus.byte_data  = byte_data;
    assign bus.byte_valid = byte_valid;
    assign bus.frame_err  = frame_err;
    assign bus.word_valid = word_fire;
    assign bus.instr      = instr_d;

    // Word assembly registers and idle-timeout counter.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            cnt_q   <= '0;
            buf_q   <= '0;
            instr_q <= '0;
            tmo_q   <= '0;
        end else begin
            cnt_q   <= cnt_d;
            buf_q   <= buf_d;
            instr_q <= instr_d;
            tmo_q   <= tmo_d;
        end
    end

    // Flush beats a completing byte; the word strobe shares its cycle.
    always_comb begin
        cnt_d     = cnt_q;
        buf_d     = buf_q;
        instr_d   = instr_q;
        tmo_d     = '0;
        word_fire = 1'b0;
        if (idle && cnt_q != '0 && !start) tmo_d = tmo_q + 1'b1;
        if (bus.clr) begin
            cnt_d = '0;
            buf_d = '0;
        end else if (byte_valid) begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == LAST_IDX) begin
                word_fire = 1'b1;
                instr_d   = {byte_data, buf_q};
            end else begin
                for (int i = 0; i < BYTES_PER_WORD - 1; i++)
                    if (cnt_q == NW'(i)) buf_d[i] = byte_data;
            end
        end else if (frame_err) begin
            cnt_d = '0;
        end else if (tmo_q == TMO_LAST) begin
            cnt_d = '0;
        end
    end

endmodule

// File: tb/tb_uart_word_rx.sv
// Directed bench for uart_word_rx with a byte/word scoreboard.
// Build with UART_PARITY_EN to include the parity steps.
module tb_uart_word_rx;
    import uart_pkg::*;

    localparam int CPB = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   checks = 0;
    int   errors = 0;
    int   exp_ferr = 0;
    logic [7:0]  exp_b[$];
    logic [31:0] exp_w[$];
    logic [7:0]  eb;
    logic [31:0] ew;

    always #5 clk = ~clk;

    uart_word_rx_if bus();

    uart_word_rx #(
        .CLKS_PER_BIT      (CPB),
        .IDLE_TIMEOUT_BITS (40)
    ) dut (
        .clk   (clk),
        .reset (rst_n),
        .bus   (bus.slave)
    );

    task automatic check(input string name, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", name, got, exp);
        end
    endtask

    task automatic bits(input int n);
        repeat (n * CPB) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] d, input logic stop);
        bus.rx = 1'b0;
        bits(1);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            bits(1);
        end
`ifdef UART_PARITY_EN
        bus.rx = ^d;
        bits(1);
`endif
        bus.rx = stop;
        bits(1);
        bus.rx = 1'b1;
        bits(2);
    endtask

`ifdef UART_PARITY_EN
    task automatic send_par(input logic [7:0] d, input logic par);
        bus.rx = 1'b0;
        bits(1);
        for (int i = 0; i < 8; i++) begin
            bus.rx = d[i];
            bits(1);
        end
        bus.rx = par;
        bits(1);
        bus.rx = 1'b1;
        bits(3);
    endtask
`endif

    task automatic good(input logic [7:0] d);
        exp_b.push_back(d);
        send_byte(d, 1'b1);
    endtask

    task automatic send_word(input logic [31:0] w);
        exp_w.push_back(w);
        for (int i = 0; i < 4; i++) good(w[i*8 +: 8]);
    endtask

    // Scoreboard: pop expectations whenever the receiver strobes.
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.byte_valid) begin
                eb = 8'hxx;
                if (exp_b.size() > 0) eb = exp_b.pop_front();
                check("byte_data", {24'h0, bus.byte_data}, {24'h0, eb});
            end
            if (bus.word_valid) begin
                ew = 32'hxxxxxxxx;
                if (exp_w.size() > 0) ew = exp_w.pop_front();
                check("instr", bus.instr, ew);
            end
            if (bus.frame_err) begin
                check("frame_err_expected", {31'h0, exp_ferr > 0}, 32'h1);
                if (exp_ferr > 0) exp_ferr--;
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        bit hit;
        bus.rx  = 1'b1;
        bus.clr = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_byte_valid", {31'h0, bus.byte_valid}, 32'h0);
        check("rst_word_valid", {31'h0, bus.word_valid}, 32'h0);
        check("rst_frame_err", {31'h0, bus.frame_err}, 32'h0);
        check("rst_busy", {31'h0, bus.busy}, 32'h0);
        check("rst_byte_data", {24'h0, bus.byte_data}, 32'h0);
        check("rst_instr", bus.instr, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(posedge clk);

        send_word(32'h0050_0513);

        bus.rx = 1'b0;
        repeat (5) @(posedge clk);
        bus.rx = 1'b1;
        repeat (20) @(posedge clk);
        #1;
        check("glitch_busy", {31'h0, bus.busy}, 32'h0);
        check("glitch_state", {29'h0, dut.u_byte.state_q}, {29'h0, IDLE});

        exp_ferr++;
        send_byte(8'hA5, 1'b0);
        bits(2);
        send_word(32'h4433_2211);

        good(8'h99);
        good(8'h88);
        bits(50);
        send_word(32'hDEAD_BEEF);

        good(8'h01);
        good(8'h02);
        good(8'h03);
        hit = 1'b0;
        fork
            good(8'h04);
            begin
                for (int i = 0; i < 300 && !hit; i++) begin
                    @(posedge clk);
                    #1;
                    if (bus.byte_valid) begin
                        hit = 1'b1;
                        bus.clr = 1'b1;
                        @(posedge clk);
                        #1;
                        bus.clr = 1'b0;
                    end
                end
            end
        join
        check("clr_seen_byte", {31'h0, hit}, 32'h1);
        check("clr_instr_held", bus.instr, 32'hDEAD_BEEF);
        send_word(32'h8877_6655);

        good(8'hC3);
        fork
            send_byte(8'h5A, 1'b1);
            begin
                repeat (5 * CPB + 8) @(posedge clk);
                #1;
                check("busy_mid_frame", {31'h0, bus.busy}, 32'h1);
                rst_n = 1'b0;
                #1;
                check("abort_busy", {31'h0, bus.busy}, 32'h0);
                check("abort_byte_valid", {31'h0, bus.byte_valid}, 32'h0);
                check("abort_word_valid", {31'h0, bus.word_valid}, 32'h0);
                check("abort_frame_err", {31'h0, bus.frame_err}, 32'h0);
                check("abort_byte_data", {24'h0, bus.byte_data}, 32'h0);
                check("abort_instr", bus.instr, 32'h0);
            end
        join
        @(negedge clk);
        rst_n = 1'b1;
        repeat (4) @(posedge clk);
        send_word(32'h0D0C_0B0A);

`ifdef UART_PARITY_EN
        exp_ferr++;
        send_par(8'h07, 1'b0);
        exp_b.push_back(8'h07);
        send_par(8'h07, 1'b1);
`endif

        repeat (20) @(posedge clk);
        check("bytes_left", exp_b.size(), 32'h0);
        check("words_left", exp_w.size(), 32'h0);
        check("ferr_left", exp_ferr, 32'h0);
        check("final_instr", bus.instr, 32'h0D0C_0B0A);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
